// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings, error-sequence state type and the command legality check.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  // ERR_HOLD marks the second cycle of a two-cycle ERROR response.
  typedef enum logic {
    ERR_NONE = 1'b0,
    ERR_HOLD = 1'b1
  } err_state_e;

  // True when a command must be rejected without touching the bus:
  // unsupported size, or an address not aligned to the transfer size.
  function automatic logic cmd_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b1;
    case (size)
      HSIZE_BYTE: bad = 1'b0;
      HSIZE_HALF: bad = addr_lo[0];
      HSIZE_WORD: bad = (addr_lo != 2'b00);
      default:    bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/ahb_master_ctrl_if.sv
// Command, response and AHB-Lite bus signals of the initiator, bundled for port use.
// Latency: none (wires only).
// Backpressure: cmd_valid/cmd_ready on the command side, hready on the bus side.
interface ahb_master_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [2:0]        cmd_size;
  logic              cmd_signed;
  logic [DATA_W-1:0] cmd_wdata;

  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;

  logic [ADDR_W-1:0] haddr;
  logic [1:0]        htrans;
  logic              hwrite;
  logic [2:0]        hsize;
  logic [3:0]        hprot;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hready;
  logic              hresp;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_signed, cmd_wdata,
    input  hrdata, hready, hresp,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output haddr, htrans, hwrite, hsize, hprot, hwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_signed, cmd_wdata,
    output hrdata, hready, hresp,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  haddr, htrans, hwrite, hsize, hprot, hwdata
  );
endinterface

// File: rtl/ahb_lane_fmt.sv
// Byte-lane formatting: store replication onto hwdata and load lane extract with sign/zero extend.
// Latency: purely combinational.
// Backpressure: none; follows whatever the pipeline registers present.
module ahb_lane_fmt
  import ahb_pkg::*;
(
  input  logic [31:0] st_data,
  input  logic [2:0]  st_size,
  output logic [31:0] st_lanes,
  input  logic [31:0] ld_data,
  input  logic [1:0]  ld_addr,
  input  logic [2:0]  ld_size,
  input  logic        ld_signed,
  output logic [31:0] ld_ext
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Store: replicate right-justified data onto every lane so any slave lane mux sees it.
  always_comb begin
    st_lanes = st_data;
    case (st_size)
      HSIZE_BYTE: st_lanes = {4{st_data[7:0]}};
      HSIZE_HALF: st_lanes = {2{st_data[15:0]}};
      default:    st_lanes = st_data;
    endcase
  end

  // Load: pick the little-endian lane addressed by the low address bits, then extend.
  always_comb begin
    byte_v = ld_data[7:0];
    case (ld_addr)
      2'd0: byte_v = ld_data[7:0];
      2'd1: byte_v = ld_data[15:8];
      2'd2: byte_v = ld_data[23:16];
      2'd3: byte_v = ld_data[31:24];
      default: byte_v = ld_data[7:0];
    endcase
    half_v = ld_addr[1] ? ld_data[31:16] : ld_data[15:0];
    ld_ext = ld_data;
    case (ld_size)
      HSIZE_BYTE: ld_ext = {{24{ld_signed & byte_v[7]}}, byte_v};
      HSIZE_HALF: ld_ext = {{16{ld_signed & half_v[15]}}, half_v};
      default:    ld_ext = ld_data;
    endcase
  end

endmodule

// File: rtl/ahb_master_ctrl.sv
// AHB-Lite initiator: turns a valid/ready command stream into pipelined single NONSEQ transfers.
// Latency: accept at edge N -> NONSEQ in N+1 -> data phase N+2 -> rsp_valid in N+3 (zero waits).
// Backpressure: cmd_ready drops while the address phase is stalled by hready, during error recovery, and for illegal commands until the pipe drains.
module ahb_master_ctrl
  import ahb_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter int         DATA_W    = 32,
  parameter logic [3:0] HPROT_DEF = 4'b0011
) (
  input logic               hclk,
  input logic               hresetn,
  ahb_master_ctrl_if.master bus
);

  typedef struct packed {
    logic              vld;
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [2:0]        size;
    logic              sgn;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  // ap: address phase (drives the bus), dp: data phase, rp: replay slot after ERROR.
  cmd_t ap_q, ap_d, dp_q, dp_d, rp_q, rp_d;
  cmd_t new_cmd;
  err_state_e err_q, err_d;

  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic cmd_bad, ready_base, cmd_ready, accept_bus, accept_bad, err_first;
  logic [31:0] st_lanes, ld_ext;

  ahb_lane_fmt u_lane_fmt (
    .st_data  (dp_q.wdata),
    .st_size  (dp_q.size),
    .st_lanes (st_lanes),
    .ld_data  (bus.hrdata),
    .ld_addr  (dp_q.addr[1:0]),
    .ld_size  (dp_q.size),
    .ld_signed(dp_q.sgn),
    .ld_ext   (ld_ext)
  );

  // Command acceptance: illegal commands wait for an empty pipe so their response stays in order.
  always_comb begin
    new_cmd    = '{vld: 1'b1, write: bus.cmd_write, addr: bus.cmd_addr,
                   size: bus.cmd_size, sgn: bus.cmd_signed, wdata: bus.cmd_wdata};
    cmd_bad    = cmd_illegal(bus.cmd_size, bus.cmd_addr[1:0]);
    ready_base = (!ap_q.vld || bus.hready) && !rp_q.vld && (err_q == ERR_NONE);
    cmd_ready  = ready_base && (!cmd_bad || (!ap_q.vld && !dp_q.vld));
    accept_bus = bus.cmd_valid && cmd_ready && !cmd_bad;
    accept_bad = bus.cmd_valid && cmd_ready && cmd_bad;
    // First ERROR cycle: the slave flags ERROR while still holding hready low.
    err_first  = dp_q.vld && bus.hresp && !bus.hready && (err_q == ERR_NONE);
  end

  // Pipeline advance and error-recovery next state.
  always_comb begin
    ap_d  = ap_q;
    dp_d  = dp_q;
    rp_d  = rp_q;
    err_d = err_q;
    if (err_first) begin
      // Cancel the pending address phase; it is parked and reissued unchanged later.
      err_d = ERR_HOLD;
      rp_d  = ap_q.vld ? ap_q : (accept_bus ? new_cmd : '0);
      ap_d  = '0;
    end else if (bus.hready) begin
      err_d = ERR_NONE;
      dp_d  = ap_q;
      if (rp_q.vld) begin
        ap_d = rp_q;
        rp_d = '0;
      end else if (accept_bus) begin
        ap_d = new_cmd;
      end else begin
        ap_d = '0;
      end
    end else if (accept_bus) begin
      ap_d = new_cmd;
    end
  end

  // Response: data phase completion, or immediate error for a rejected command.
  always_comb begin
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    if (dp_q.vld && bus.hready) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = (bus.hresp == HRESP_ERROR);
      if (!dp_q.write && (bus.hresp == HRESP_OKAY)) rsp_rdata_d = ld_ext;
    end else if (accept_bad) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = 1'b1;
    end
  end

  // Error-sequence state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) err_q <= ERR_NONE;
    else          err_q <= err_d;
  end

  // Pipeline and response registers; reset drops all in-flight commands.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      ap_q        <= '0;
      dp_q        <= '0;
      rp_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      ap_q        <= ap_d;
      dp_q        <= dp_d;
      rp_q        <= rp_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.htrans    = ap_q.vld ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr     = ap_q.addr;
  assign bus.hwrite    = ap_q.write;
  assign bus.hsize     = ap_q.size;
  assign bus.hprot     = ap_q.vld ? HPROT_DEF : 4'b0000;
  assign bus.hwdata    = (dp_q.vld && dp_q.write) ? st_lanes : '0;

endmodule

// File: tb/tb_ahb_master_ctrl.sv
// Self-checking bench for ahb_master_ctrl: vector table plus hand sequences for waits, errors and reset.
// Latency: responses are matched in order against a scoreboard queue.
// Backpressure: slave side hready/hresp are driven directly by the sequences.
module tb_ahb_master_ctrl;

  logic hclk = 1'b0;
  logic hresetn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [32:0] sb_q[$];
  logic [31:0] s_addr;

  ahb_master_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ahb_master_ctrl #(.ADDR_W(32), .DATA_W(32), .HPROT_DEF(4'b0011)) dut (
    .hclk   (hclk),
    .hresetn(hresetn),
    .bus    (bus)
  );

  always #5 hclk = ~hclk;

  // Slave read data: fixed pattern per aligned word, with two special words for lane tests.
  function automatic logic [31:0] rd_pat(input logic [31:0] a);
    logic [31:0] w;
    logic [7:0]  b;
    w = a & 32'hFFFF_FFFC;
    b = w[7:0];
    if (w == 32'h100) return 32'h8000_0000;
    if (w == 32'h200) return 32'hC3A5_7F80;
    return {b + 8'h11, b + 8'h22, b + 8'h33, b + 8'h44};
  endfunction

  always @(posedge hclk or negedge hresetn) begin
    if (!hresetn) s_addr <= 32'h0;
    else if (bus.hready) s_addr <= (bus.htrans == 2'b10) ? bus.haddr : 32'h0;
  end
  assign bus.hrdata = rd_pat(s_addr);

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every response pulse is compared with the oldest pushed expectation.
  always @(negedge hclk) begin
    if (hresetn && bus.rsp_valid) begin
      if (sb_q.size() == 0) begin
        check("rsp_unexpected", 64'd1, 64'd0);
      end else begin
        logic [32:0] e;
        e = sb_q.pop_front();
        check("rsp", {31'd0, bus.rsp_err, bus.rsp_rdata}, {31'd0, e});
      end
    end
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  // Offers one command; returns one step after the accepting edge (address phase cycle).
  task automatic send(input logic w, input logic [31:0] a, input logic [2:0] sz, input logic sg,
                      input logic [31:0] wd, input logic [31:0] er, input logic ee, input logic push);
    logic done;
    done = 1'b0;
    bus.cmd_valid  = 1'b1;
    bus.cmd_write  = w;
    bus.cmd_addr   = a;
    bus.cmd_size   = sz;
    bus.cmd_signed = sg;
    bus.cmd_wdata  = wd;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge hclk);
      if (bus.cmd_ready) begin
        if (push) sb_q.push_back({ee, er});
        done = 1'b1;
      end
      step();
    end
    bus.cmd_valid = 1'b0;
    check("accept", {63'd0, done}, 64'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 50 && sb_q.size() != 0; i++) step();
    check("drain", 64'(sb_q.size()), 64'd0);
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  sz;
    logic        sg;
    logic [31:0] wd;
    logic [31:0] er;
    logic        ee;
  } vec_t;

  vec_t tbl[17];

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b0, 32'h000, 3'd2, 1'b0, 32'h0, 32'h1122_3344, 1'b0};
    tbl[1]  = '{1'b0, 32'h004, 3'd2, 1'b0, 32'h0, 32'h1526_3748, 1'b0};
    tbl[2]  = '{1'b0, 32'h008, 3'd2, 1'b0, 32'h0, 32'h192A_3B4C, 1'b0};
    tbl[3]  = '{1'b0, 32'h103, 3'd0, 1'b1, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[4]  = '{1'b0, 32'h103, 3'd0, 1'b0, 32'h0, 32'h0000_0080, 1'b0};
    tbl[5]  = '{1'b0, 32'h202, 3'd1, 1'b1, 32'h0, 32'hFFFF_C3A5, 1'b0};
    tbl[6]  = '{1'b0, 32'h200, 3'd1, 1'b1, 32'h0, 32'h0000_7F80, 1'b0};
    tbl[7]  = '{1'b0, 32'h201, 3'd0, 1'b1, 32'h0, 32'h0000_007F, 1'b0};
    tbl[8]  = '{1'b0, 32'h200, 3'd0, 1'b1, 32'h0, 32'hFFFF_FF80, 1'b0};
    tbl[9]  = '{1'b0, 32'h202, 3'd0, 1'b0, 32'h0, 32'h0000_00A5, 1'b0};
    tbl[10] = '{1'b1, 32'h104, 3'd2, 1'b0, 32'h1234_5678, 32'h0, 1'b0};
    tbl[11] = '{1'b1, 32'h102, 3'd1, 1'b0, 32'hABCD_1234, 32'h0, 1'b0};
    tbl[12] = '{1'b0, 32'h000, 3'd3, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[13] = '{1'b0, 32'h006, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1};
    tbl[14] = '{1'b0, 32'h008, 3'd0, 1'b0, 32'h0, 32'h0000_004C, 1'b0};
    tbl[15] = '{1'b0, 32'h006, 3'd1, 1'b1, 32'h0, 32'h0000_1526, 1'b0};
    tbl[16] = '{1'b0, 32'h102, 3'd1, 1'b0, 32'h0, 32'h0000_8000, 1'b0};

    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0;
    bus.cmd_size = 3'd0; bus.cmd_signed = 1'b0; bus.cmd_wdata = 32'h0;
    bus.hready = 1'b1; bus.hresp = 1'b0;

    // Reset state
    repeat (3) @(posedge hclk);
    #1;
    check("rst_htrans", 64'(bus.htrans), 64'd0);
    check("rst_haddr", 64'(bus.haddr), 64'd0);
    check("rst_hprot_hwdata", {28'd0, bus.hprot, bus.hwdata}, 64'd0);
    check("rst_rsp", {31'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_rdata[30:0]}, 64'd0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd1);
    hresetn = 1'b1;
    step();

    // Word write: NONSEQ one cycle after accept, data phase next, response at N+3
    send(1'b1, 32'h100, 3'd2, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0, 1'b1);
    check("w1_addr_phase", {26'd0, bus.htrans, bus.hwrite, bus.hsize, bus.hprot, bus.haddr[23:0]},
          {26'd0, 2'b10, 1'b1, 3'd2, 4'b0011, 24'h000100});
    step();
    check("w1_hwdata", 64'(bus.hwdata), 64'hDEAD_BEEF);
    check("w1_idle", 64'(bus.htrans), 64'd0);
    step();
    check("w1_rsp_n3", {62'd0, bus.rsp_valid, bus.rsp_err}, 64'b10);
    send(1'b1, 32'h106, 3'd1, 1'b0, 32'hABCD_1234, 32'h0, 1'b0, 1'b1);
    step();
    check("half_hwdata", 64'(bus.hwdata), 64'h1234_1234);
    drain();

    // Vector table, issued back to back
    for (int i = 0; i < 17; i++) begin
      send(tbl[i].w, tbl[i].a, tbl[i].sz, tbl[i].sg, tbl[i].wd, tbl[i].er, tbl[i].ee, 1'b1);
      check($sformatf("vec%0d_htrans", i), 64'(bus.htrans), tbl[i].ee ? 64'd0 : 64'd2);
      if (!tbl[i].ee)
        check($sformatf("vec%0d_addr", i), {28'd0, bus.hprot, bus.haddr}, {28'd0, 4'b0011, tbl[i].a});
    end
    drain();

    // Wait states: AP and hwdata hold, no acceptance while AP is full
    send(1'b1, 32'h300, 3'd2, 1'b0, 32'h0BAD_F00D, 32'h0, 1'b0, 1'b1);
    send(1'b1, 32'h304, 3'd0, 1'b0, 32'h1234_565A, 32'h0, 1'b0, 1'b1);
    bus.hready = 1'b0;
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h8; bus.cmd_size = 3'd2;
    for (int k = 0; k < 2; k++) begin
      #1;
      check("ws_ap_hold", {30'd0, bus.htrans, bus.haddr}, {30'd0, 2'b10, 32'h304});
      check("ws_hwdata_hold", 64'(bus.hwdata), 64'h0BAD_F00D);
      check("ws_ready_low", 64'(bus.cmd_ready), 64'd0);
      step();
    end
    bus.cmd_valid = 1'b0;
    bus.hready = 1'b1;
    #1;
    check("ws_ready_back", 64'(bus.cmd_ready), 64'd1);
    step();
    check("ws_byte_hwdata", 64'(bus.hwdata), 64'h5A5A_5A5A);
    drain();

    // Two-cycle ERROR on read 0x0 with read 0x4 pending in the address phase
    send(1'b0, 32'h000, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    send(1'b0, 32'h004, 3'd2, 1'b0, 32'h0, 32'h1526_3748, 1'b0, 1'b1);
    bus.hresp = 1'b1; bus.hready = 1'b0;
    #1;
    check("err_c1_ready", 64'(bus.cmd_ready), 64'd0);
    step();
    bus.hready = 1'b1;
    #1;
    check("err_c2_idle", 64'(bus.htrans), 64'd0);
    check("err_c2_ready", 64'(bus.cmd_ready), 64'd0);
    step();
    bus.hresp = 1'b0;
    #1;
    check("err_rsp", {62'd0, bus.rsp_valid, bus.rsp_err}, 64'b11);
    check("err_replay", {30'd0, bus.htrans, bus.haddr}, {30'd0, 2'b10, 32'h4});
    drain();

    // ERROR with hready high and no first cycle: completes as error, nothing replayed
    send(1'b0, 32'h008, 3'd2, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
    step();
    bus.hresp = 1'b1;
    step();
    bus.hresp = 1'b0;
    #1;
    check("err1c_rsp", {62'd0, bus.rsp_valid, bus.rsp_err}, 64'b11);
    check("err1c_no_replay", 64'(bus.htrans), 64'd0);
    drain();

    // Misaligned half write: no transfer, error response next cycle
    send(1'b1, 32'h101, 3'd1, 1'b0, 32'h55AA, 32'h0, 1'b1, 1'b1);
    check("mis_no_xfer", 64'(bus.htrans), 64'd0);
    check("mis_rsp", {62'd0, bus.rsp_valid, bus.rsp_err}, 64'b11);
    drain();

    // Reset in the middle of a wait state drops in-flight commands
    send(1'b0, 32'h010, 3'd2, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
    send(1'b1, 32'h014, 3'd2, 1'b0, 32'h7777_7777, 32'h0, 1'b0, 1'b0);
    bus.hready = 1'b0;
    step();
    hresetn = 1'b0;
    #1;
    check("rst_mid_htrans", 64'(bus.htrans), 64'd0);
    check("rst_mid_rsp", 64'(bus.rsp_valid), 64'd0);
    bus.hready = 1'b1;
    step();
    step();
    hresetn = 1'b1;
    repeat (5) step();
    check("rst_mid_quiet", {62'd0, bus.htrans}, 64'd0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
